// File: rtl/scan_pkg.sv
// Shared widths for the scan select generator.
package scan_pkg;
  localparam int SEL_W      = 2;
  localparam int NUM_DIGITS = 4;
  localparam int NIB_W      = 4;
  localparam int DIG_W      = NUM_DIGITS * NIB_W;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [NIB_W-1:0] nib_t;
endpackage

// File: rtl/decoder_24.sv
// 2-to-4 one-hot decoder fed by the scan select pair (a = MSB).
module decoder_24 (
  input  logic       a,
  input  logic       b,
  output logic [3:0] y
);
  assign y = 4'b0001 << {a, b};
endmodule

// File: rtl/scan_prescaler.sv
// Enable-gated prescaler: advance is high on the enabled cycle that completes
// each PRESCALE-count interval; a partial count survives en dropping low.
module scan_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic advance
);
  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;

  assign advance = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst)          cnt <= '0;
    else if (advance) cnt <= '0;
    else if (en)      cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/scan_sel_gen.sv
// Scan select sequencer: steps {a,b} at a prescaled rate with an aligned nibble.
// Define SCAN_DIR_EN to add the dir input for down-counting scans.
module scan_sel_gen
  import scan_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
`ifdef SCAN_DIR_EN
  input  logic             dir,
`endif
  input  logic [DIG_W-1:0] digits,
  output logic             a,
  output logic             b,
  output nib_t             nibble,
  output logic             tick,
  output logic             frame
);
  logic advance;
  logic down;
  sel_t sel, sel_next;

`ifdef SCAN_DIR_EN
  assign down = dir;
`else
  assign down = 1'b0;
`endif

  scan_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .advance (advance)
  );

  always_comb begin
    sel_next = sel;
    if (advance) sel_next = down ? sel - 1'b1 : sel + 1'b1;
  end

  // The nibble is looked up with sel_next so it lands in the same cycle as {a,b}.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel    <= '0;
      nibble <= '0;
      tick   <= 1'b0;
      frame  <= 1'b0;
    end else begin
      sel    <= sel_next;
      nibble <= digits[NIB_W*sel_next +: NIB_W];
      tick   <= advance;
      frame  <= advance && (down ? (sel == sel_t'(0)) : (sel == sel_t'(NUM_DIGITS-1)));
    end
  end

  assign a = sel[1];
  assign b = sel[0];
endmodule
